pipe_hazard_ctrl: RTL and testbench

- Pipeline control block that drives the enable and flush inputs of the FD and DX latches and the PC register.
- Also inserts bubbles into XM.
- Detects load-use hazards from the DX-stage destination and load flag against the FD-stage sources.
- Sequences multi-cycle mult/div operations with a start-pulse/ready handshake to the multdiv unit, and applies branch/jump flushes from X.

---
 rtl/pipe_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Pipeline hazard / sequencing controller. Drives the PC, FD and DX latch
// enables and flushes, and inserts XM bubbles. It detects load-use hazards
// (DX load vs FD sources) and applies branch/jump flushes resolved in X. It
// also sequences multi-cycle mult/div operations through a start-pulse /
// ready handshake with the multdiv unit, with a timeout guard.
//
// Optional feature macro: STALL_COUNT_EN
//   When defined, adds output stall_cycles (32 bit). It counts every cycle in
//   which pc_enable is low, clears on reset and wraps naturally.
//
// Parameters
//   MD_MAX_CYCLES  MD_BUSY cycles allowed before a timeout is declared
//   CNT_W          width of the busy-cycle counter (2**CNT_W > MD_MAX_CYCLES)
//
// Ports
//   clk             in   pipeline clock
//   reset           in   synchronous, active-low reset
//   Opcode_DX       in   opcode of DX instruction
//   ALUop_DX        in   ALU opcode of DX instruction
//   Rd_DX_bypass    in   destination register of DX instruction
//   Rs1_FD, Rs2_FD  in   source registers of FD instruction
//   rs2_used_FD     in   FD instruction actually reads Rs2
//   branch_taken_X  in   taken branch/jump resolved in X this cycle
//   md_ready        in   multdiv result valid pulse
//   md_exception    in   multdiv exception, qualified by md_ready
//   pc_enable       out  PC write enable
//   fd_enable       out  FD latch enable
//   dx_enable       out  DX latch enable
//   fd_flush        out  load nop into FD
//   dx_flush        out  load nop into DX
//   xm_bubble       out  XM captures nop instead of X results
//   ctrl_MULT       out  multiply start pulse
//   ctrl_DIV        out  divide start pulse
//   md_done         out  multdiv result valid for XM capture
//   md_timeout      out  sticky timeout flag (cleared only by reset)
//   stall_cycles    out  frozen-PC cycle count (STALL_COUNT_EN only)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MD_MAX_CYCLES = 40,
  parameter int CNT_W         = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Opcode_DX,
  input  logic [4:0]  ALUop_DX,
  input  logic [4:0]  Rd_DX_bypass,
  input  logic [4:0]  Rs1_FD,
  input  logic [4:0]  Rs2_FD,
  input  logic        rs2_used_FD,
  input  logic        branch_taken_X,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic        pc_enable,
  output logic        fd_enable,
  output logic        dx_enable,
  output logic        fd_flush,
  output logic        dx_flush,
  output logic        xm_bubble,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        md_done,
`ifdef STALL_COUNT_EN
  output logic [31:0] stall_cycles,
`endif
  output logic        md_timeout
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LOAD  = 5'b01000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  // Last busy-cycle index before the timeout fires (counter starts at 0).
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_START = 2'd1,
    MD_BUSY  = 2'd2,
    MD_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             timeout_q, timeout_d;

  logic dx_is_load, dx_is_mul, dx_is_div, load_use;

  // The exception flag is passed to XM by the datapath; control only needs
  // md_ready to sequence.
  logic unused_md_exception;
  assign unused_md_exception = md_exception;

  assign dx_is_load = (Opcode_DX == OP_LOAD);
  assign dx_is_mul  = (Opcode_DX == OP_RTYPE) && (ALUop_DX == ALU_MUL);
  assign dx_is_div  = (Opcode_DX == OP_RTYPE) && (ALUop_DX == ALU_DIV);

  // r0 is hard-wired zero, so a load targeting it never produces a hazard.
  assign load_use = dx_is_load && (Rd_DX_bypass != 5'd0) &&
                    ((Rd_DX_bypass == Rs1_FD) ||
                     (rs2_used_FD && (Rd_DX_bypass == Rs2_FD)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    timeout_d = timeout_q;

    pc_enable = 1'b1;
    fd_enable = 1'b1;
    dx_enable = 1'b1;
    fd_flush  = 1'b0;
    dx_flush  = 1'b0;
    xm_bubble = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    md_done   = 1'b0;

    unique case (state_q)
      RUN: begin
        if (branch_taken_X) begin
          // Branch wins over a load stall: the stalled instruction is
          // squashed anyway.
          fd_flush = 1'b1;
          dx_flush = 1'b1;
        end else if (load_use) begin
          // Hold PC/FD and drop a nop into DX; the nop clears the hazard
          // next cycle, so this is always a single stall.
          pc_enable = 1'b0;
          fd_enable = 1'b0;
          dx_flush  = 1'b1;
        end else if (dx_is_mul || dx_is_div) begin
          // Remember the op kind: DX may reload this edge.
          state_d  = MD_START;
          is_div_d = dx_is_div;
        end
      end

      MD_START: begin
        pc_enable = 1'b0;
        fd_enable = 1'b0;
        dx_enable = 1'b0;
        xm_bubble = 1'b1;
        ctrl_MULT = ~is_div_q;
        ctrl_DIV  = is_div_q;
        cnt_d     = '0;
        state_d   = MD_BUSY;
      end

      MD_BUSY: begin
        pc_enable = 1'b0;
        fd_enable = 1'b0;
        dx_enable = 1'b0;
        xm_bubble = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (md_ready) begin
          state_d = MD_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = MD_DONE;
        end
      end

      MD_DONE: begin
        md_done = 1'b1;
        state_d = RUN;
      end

      default: state_d = RUN;
    endcase

    // While reset is held the pipeline sees plain free-running control.
    if (!reset) begin
      pc_enable = 1'b1;
      fd_enable = 1'b1;
      dx_enable = 1'b1;
      fd_flush  = 1'b0;
      dx_flush  = 1'b0;
      xm_bubble = 1'b0;
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      md_done   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      timeout_q <= timeout_d;
    end
  end

  assign md_timeout = timeout_q;

`ifdef STALL_COUNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (!pc_enable) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int MD_MAX = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Opcode_DX, ALUop_DX, Rd_DX_bypass, Rs1_FD, Rs2_FD;
  logic       rs2_used_FD, branch_taken_X, md_ready, md_exception;
  logic       pc_enable, fd_enable, dx_enable, fd_flush, dx_flush;
  logic       xm_bubble, ctrl_MULT, ctrl_DIV, md_done, md_timeout;
`ifdef STALL_COUNT_EN
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MD_MAX_CYCLES(MD_MAX), .CNT_W(6)) dut (
    .clk(clk), .reset(reset),
    .Opcode_DX(Opcode_DX), .ALUop_DX(ALUop_DX), .Rd_DX_bypass(Rd_DX_bypass),
    .Rs1_FD(Rs1_FD), .Rs2_FD(Rs2_FD), .rs2_used_FD(rs2_used_FD),
    .branch_taken_X(branch_taken_X), .md_ready(md_ready),
    .md_exception(md_exception),
    .pc_enable(pc_enable), .fd_enable(fd_enable), .dx_enable(dx_enable),
    .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_bubble(xm_bubble),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .md_done(md_done),
`ifdef STALL_COUNT_EN
    .stall_cycles(stall_cycles),
`endif
    .md_timeout(md_timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks the multdiv operation as "start cycle number" and
  // "done cycle number" and derives every output from the rules directly.
  // ---------------------------------------------------------------------------
  int          m_cyc     = 0;
  bit          m_in_op   = 0;
  int          m_start   = -1;
  int          m_done_at = -1;
  bit          m_div     = 0;
  bit          m_tmo     = 0;
  logic [31:0] m_stalls  = 0;

  always @(negedge clk) begin
    logic [9:0] exp_v, act_v;
    logic e_pc, e_fd, e_dx, e_ff, e_df, e_bub, e_mul, e_div, e_done;
    bit   nxt_tmo;
    e_pc = 1; e_fd = 1; e_dx = 1; e_ff = 0; e_df = 0;
    e_bub = 0; e_mul = 0; e_div = 0; e_done = 0;
    nxt_tmo = m_tmo;

    if (!reset) begin
      m_in_op = 0;
      nxt_tmo = 0;
    end else if (!m_in_op) begin
      if (branch_taken_X) begin
        e_ff = 1; e_df = 1;
      end else if (Opcode_DX == 5'd8 && Rd_DX_bypass != 0 &&
                   (Rd_DX_bypass == Rs1_FD || (rs2_used_FD && Rd_DX_bypass == Rs2_FD))) begin
        e_pc = 0; e_fd = 0; e_df = 1;
      end else if (Opcode_DX == 5'd0 && (ALUop_DX == 5'd6 || ALUop_DX == 5'd7)) begin
        m_in_op   = 1;
        m_start   = m_cyc + 1;
        m_done_at = -1;
        m_div     = (ALUop_DX == 5'd7);
      end
    end else if (m_cyc == m_start) begin
      e_pc = 0; e_fd = 0; e_dx = 0; e_bub = 1;
      e_mul = !m_div; e_div = m_div;
    end else if (m_cyc == m_done_at) begin
      e_done  = 1;
      m_in_op = 0;
    end else begin
      e_pc = 0; e_fd = 0; e_dx = 0; e_bub = 1;
      if (md_ready) begin
        m_done_at = m_cyc + 1;
      end else if (m_cyc - m_start == MD_MAX) begin
        nxt_tmo   = 1;
        m_done_at = m_cyc + 1;
      end
    end

    exp_v = {e_pc, e_fd, e_dx, e_ff, e_df, e_bub, e_mul, e_div, e_done, m_tmo};
    act_v = {pc_enable, fd_enable, dx_enable, fd_flush, dx_flush, xm_bubble,
             ctrl_MULT, ctrl_DIV, md_done, md_timeout};
    chk("model_outputs", 32'(act_v), 32'(exp_v));
`ifdef STALL_COUNT_EN
    chk("model_stall_cycles", stall_cycles, m_stalls);
`endif
    if (!reset) m_stalls = 0;
    else if (!e_pc) m_stalls = m_stalls + 32'd1;
    m_tmo = nxt_tmo;
    m_cyc++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic set_idle();
    Opcode_DX = 5'b00001; ALUop_DX = 5'd0; Rd_DX_bypass = 5'd9;
    Rs1_FD = 5'd10; Rs2_FD = 5'd11; rs2_used_FD = 1'b1;
    branch_taken_X = 1'b0; md_ready = 1'b0; md_exception = 1'b0;
  endtask

  task automatic rand_inputs();
    int r;
    r = $urandom_range(0, 9);
    Opcode_DX = (r < 3) ? 5'd0 : (r < 6) ? 5'd8 : 5'($urandom);
    r = $urandom_range(0, 9);
    ALUop_DX = (r < 4) ? 5'($urandom_range(6, 7)) : 5'($urandom);
    Rd_DX_bypass   = 5'($urandom_range(0, 7));
    Rs1_FD         = 5'($urandom_range(0, 7));
    Rs2_FD         = 5'($urandom_range(0, 7));
    rs2_used_FD    = 1'($urandom);
    branch_taken_X = ($urandom_range(0, 9) == 0);
    md_ready       = ($urandom_range(0, 29) == 0);
    md_exception   = 1'($urandom);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int mult_hi;

    // Reset held low for two cycles with random inputs.
    reset = 1'b0;
    rand_inputs();
    for (int i = 0; i < 2; i++) begin
      if (i > 0) begin next_cycle(); rand_inputs(); end
      @(negedge clk);
      chk("rst_pc_enable", 32'(pc_enable), 1);
      chk("rst_flush_bubble_ctrl",
          32'({fd_flush, dx_flush, xm_bubble, ctrl_MULT, ctrl_DIV, md_done}), 0);
      chk("rst_md_timeout", 32'(md_timeout), 0);
    end
    next_cycle(); reset = 1'b1; set_idle();
    @(negedge clk);
    chk("run_idle_enables", 32'({pc_enable, fd_enable, dx_enable}), 32'b111);

    // Load-use on Rs1.
    next_cycle(); set_idle();
    Opcode_DX = 5'd8; Rd_DX_bypass = 5'd5; Rs1_FD = 5'd5;
    @(negedge clk);
    chk("lu_stall", 32'({pc_enable, fd_enable, dx_flush}), 32'b001);
    next_cycle(); set_idle();   // nop now in DX
    @(negedge clk);
    chk("lu_one_cycle", 32'({pc_enable, fd_enable, dx_flush}), 32'b110);

    // Rd = 0 never stalls.
    next_cycle(); set_idle();
    Opcode_DX = 5'd8; Rd_DX_bypass = 5'd0; Rs1_FD = 5'd0;
    @(negedge clk);
    chk("lu_r0_no_stall", 32'(pc_enable), 1);

    // Rs2 match with rs2 unused: no stall; with rs2 used: stall.
    next_cycle(); set_idle();
    Opcode_DX = 5'd8; Rd_DX_bypass = 5'd5; Rs1_FD = 5'd6; Rs2_FD = 5'd5; rs2_used_FD = 1'b0;
    @(negedge clk);
    chk("lu_rs2_unused", 32'(pc_enable), 1);
    next_cycle();
    rs2_used_FD = 1'b1;
    @(negedge clk);
    chk("lu_rs2_used", 32'({pc_enable, dx_flush}), 32'b01);

    // Branch beats load-use.
    next_cycle(); set_idle();
    Opcode_DX = 5'd8; Rd_DX_bypass = 5'd3; Rs1_FD = 5'd3; branch_taken_X = 1'b1;
    @(negedge clk);
    chk("br_over_lu", 32'({fd_flush, dx_flush, pc_enable}), 32'b111);

    // MUL with md_ready 17 cycles after ctrl_MULT.
    next_cycle(); set_idle();
    Opcode_DX = 5'd0; ALUop_DX = 5'd6;
    @(negedge clk);
    chk("mul_run_defaults", 32'({ctrl_MULT, pc_enable, xm_bubble}), 32'b010);
    mult_hi = 0;
    for (int i = 1; i <= 21; i++) begin
      next_cycle(); set_idle();
      if (i == 18) md_ready = 1'b1;
      @(negedge clk);
      mult_hi += int'(ctrl_MULT);
      if (i == 1) chk("mul_start", 32'({ctrl_MULT, ctrl_DIV, xm_bubble, pc_enable}), 32'b1010);
      if (i >= 2 && i <= 18) chk("mul_busy", 32'({pc_enable, dx_enable, xm_bubble}), 32'b001);
      if (i == 19) chk("mul_done", 32'({md_done, pc_enable, xm_bubble}), 32'b110);
      if (i == 20) chk("mul_back_run", 32'({md_done, pc_enable}), 32'b01);
    end
    chk("mul_pulse_count", 32'(mult_hi), 1);

    // DIV with no md_ready: timeout after 40 busy cycles.
    next_cycle(); set_idle();
    Opcode_DX = 5'd0; ALUop_DX = 5'd7;
    for (int i = 1; i <= 45; i++) begin
      next_cycle(); set_idle();
      @(negedge clk);
      if (i == 1) chk("div_start", 32'({ctrl_DIV, ctrl_MULT}), 32'b10);
      if (i == 41) chk("div_no_tmo_yet", 32'({md_timeout, xm_bubble}), 32'b01);
      if (i == 42) chk("div_tmo_done", 32'({md_timeout, md_done, pc_enable}), 32'b111);
      if (i == 45) chk("div_tmo_sticky", 32'({md_timeout, pc_enable}), 32'b11);
    end
    next_cycle(); reset = 1'b0;
    @(negedge clk);
    next_cycle(); reset = 1'b1;
    @(negedge clk);
    chk("tmo_cleared", 32'(md_timeout), 0);

    // Reset during MD_BUSY, then a stray md_ready.
    next_cycle(); set_idle();
    Opcode_DX = 5'd0; ALUop_DX = 5'd6;
    for (int i = 1; i <= 8; i++) begin
      next_cycle(); set_idle();
      if (i == 5) reset = 1'b0;
      if (i == 6) begin reset = 1'b1; md_ready = 1'b1; end
      if (i == 7) begin Opcode_DX = 5'd8; Rd_DX_bypass = 5'd4; Rs1_FD = 5'd4; end
      @(negedge clk);
      if (i == 6) begin
        chk("rst_busy_run", 32'({md_done, pc_enable, xm_bubble}), 32'b010);
`ifdef STALL_COUNT_EN
        chk("stall_after_rst", stall_cycles, 0);
`endif
      end
      if (i == 7) chk("rst_busy_no_done", 32'({md_done, pc_enable}), 32'b00);
`ifdef STALL_COUNT_EN
      if (i == 8) chk("stall_one", stall_cycles, 1);
`endif
    end

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      rand_inputs();
      reset = ($urandom_range(0, 199) != 0);
    end
    next_cycle();
    reset = 1'b1; set_idle();
    @(negedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
